// File: rtl/tdm_demux_rx.sv
// TDM frame receiver. It locks to fsync and splits a serial 4-slot frame into
// per-channel words, flagging and counting framing violations.
module tdm_demux_rx #(
   parameter int SLOT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              din_valid,
   input  logic              fsync,
   output logic [SLOT_W-1:0] ch0_data,
   output logic [SLOT_W-1:0] ch1_data,
   output logic [SLOT_W-1:0] ch2_data,
   output logic [SLOT_W-1:0] ch3_data,
   output logic [3:0]        ch_valid,
   output logic              locked,
   output logic              frame_err,
   output logic [7:0]        err_cnt
);

   localparam int BIT_W = $clog2(SLOT_W);
   localparam int SR_W  = SLOT_W - 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W - 1);

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [1:0]        slot_r;
   logic [SR_W-1:0]   sr_r;
   logic [SLOT_W-1:0] ch_r [4];
   logic [3:0]        ch_valid_r;
   logic              frame_err_r;
   logic [7:0]        err_cnt_r;

   logic              at_start_s;
   logic              restart_s;
   logic              shift_s;
   logic              err_s;
   logic [SLOT_W-1:0] word_s;

   // Only the low SLOT_W-1 bits are kept; the completed word is formed with the final din bit.
   assign at_start_s = (slot_r == 2'd0) && (bit_cnt_r == {BIT_W{1'b0}});
   assign word_s     = {sr_r, din};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= HUNT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and beat classification: restart at slot 0, plain shift, or framing error
   always_comb begin
      state_s   = state_r;
      restart_s = 1'b0;
      shift_s   = 1'b0;
      err_s     = 1'b0;
      if (din_valid) begin
         case (state_r)
            HUNT: begin
               if (fsync) begin
                  restart_s = 1'b1;
                  state_s   = LOCK;
               end else begin
                  state_s   = HUNT;
               end
            end
            LOCK: begin
               if (at_start_s) begin
                  if (fsync) begin
                     restart_s = 1'b1;
                  end else begin
                     err_s   = 1'b1;
                     state_s = HUNT;
                  end
               end else if (fsync) begin
                  err_s     = 1'b1;
                  restart_s = 1'b1;
               end else begin
                  shift_s   = 1'b1;
               end
            end
            default: begin
               state_s = HUNT;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Output decode of the state register
   always_comb begin
      locked = 1'b0;
      case (state_r)
         LOCK:    locked = 1'b1;
         HUNT:    locked = 1'b0;
         default: locked = 1'b0;
      endcase
   end

   // Datapath: shift register, slot/bit counters, channel words, pulses and error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= {BIT_W{1'b0}};
         slot_r      <= 2'd0;
         sr_r        <= {SR_W{1'b0}};
         ch_valid_r  <= 4'b0000;
         frame_err_r <= 1'b0;
         err_cnt_r   <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            ch_r[i] <= {SLOT_W{1'b0}};
         end
      end else begin
         ch_valid_r  <= 4'b0000;
         frame_err_r <= err_s;
         if (err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
         if (restart_s) begin
            sr_r      <= SR_W'(din);
            bit_cnt_r <= BIT_W'(1);
            slot_r    <= 2'd0;
         end else if (shift_s) begin
            sr_r <= word_s[SR_W-1:0];
            if (bit_cnt_r == LAST_BIT) begin
               ch_r[slot_r]       <= word_s;
               ch_valid_r[slot_r] <= 1'b1;
               bit_cnt_r          <= {BIT_W{1'b0}};
               slot_r             <= slot_r + 2'd1;
            end else begin
               bit_cnt_r          <= bit_cnt_r + BIT_W'(1);
            end
         end
      end
   end

   assign ch0_data  = ch_r[0];
   assign ch1_data  = ch_r[1];
   assign ch2_data  = ch_r[2];
   assign ch3_data  = ch_r[3];
   assign ch_valid  = ch_valid_r;
   assign frame_err = frame_err_r;
   assign err_cnt   = err_cnt_r;

endmodule
